// File: rtl/bowl_pkg.sv
// Shared types and constants for the bowling lane turn sequencer.
package bowl_pkg;

  localparam int PIN_W = 10;
  localparam logic [PIN_W-1:0] ALL_PINS = 10'h3FF;

  typedef enum logic [2:0] {
    IDLE,
    READY,
    ROLL,
    SETTLE,
    REPORT,
    RACK,
    DONE
  } state_t;

endpackage

// File: rtl/bowl_settle_timer.sv
// Shared cycle counter: no-change timeout while the ball rolls, and pin-mask
// stability detection while the pins settle.
module bowl_settle_timer #(
  parameter int SETTLE_CYCLES = 16,
  parameter int ROLL_TIMEOUT  = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic roll,
  input  logic settle,
  input  logic change,
  output logic settled,
  output logic timeout
);

  localparam int CNT_MAX = (ROLL_TIMEOUT > SETTLE_CYCLES) ? ROLL_TIMEOUT : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  logic [CNT_W-1:0] cnt;

  // Any pin change restarts the count; leaving ROLL/SETTLE clears it so the
  // next ball always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!(roll || settle) || change) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign timeout = roll   && !change && (cnt == CNT_W'(ROLL_TIMEOUT - 1));
  assign settled = settle && !change && (cnt == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/bowl_turn_sequencer.sv
// Bowling lane game/turn controller: launch, settle, per-ball report, pin-setter handshake.
// Optional tenth-frame bonus balls are enabled by defining BOWL_TENTH_BONUS_EN.
module bowl_turn_sequencer
  import bowl_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int NUM_FRAMES    = 10,
  parameter int SETTLE_CYCLES = 16,
  parameter int ROLL_TIMEOUT  = 4096
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic             launch_in,
  input  logic             sensor_valid_in,
  input  logic [PIN_W-1:0] pins_standing_in,
  input  logic             rack_ack_in,
  output logic             ready_out,
  output logic             score_valid_out,
  output logic [PIN_W-1:0] pins_new_out,
  output logic [1:0]       player_out,
  output logic [1:0]       ball_out,
  output logic [3:0]       frame_out,
  output logic             rack_req_out,
  output logic             rack_full_out,
  output logic             game_over_out
);

  state_t           state;
  logic [PIN_W-1:0] standing_q;
  logic [PIN_W-1:0] rack_mask_q;
  logic [PIN_W-1:0] sampled;
  logic             change;
  logic             settled;
  logic             timeout;

  logic             all_down;
  logic             last_frame;
  logic             last_player;
  logic             full_rack;
  logic             end_turn;
  logic [1:0]       nxt_ball;

  logic             pend_end_q;
  logic             pend_done_q;
  logic [1:0]       pend_ball_q;

  // Pins that pop back up are masked off, so standing_q only ever loses bits.
  assign sampled = standing_q & pins_standing_in;
  assign change  = sensor_valid_in && (state == ROLL || state == SETTLE) &&
                   (sampled != standing_q);

  bowl_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .ROLL_TIMEOUT  (ROLL_TIMEOUT)
  ) u_timer (
    .clk     (clk_in),
    .rst_n   (rst_n_in),
    .roll    (state == ROLL),
    .settle  (state == SETTLE),
    .change  (change),
    .settled (settled),
    .timeout (timeout)
  );

  assign all_down    = (standing_q == '0);
  assign last_frame  = (frame_out == 4'(NUM_FRAMES - 1));
  assign last_player = (player_out == 2'(NUM_PLAYERS - 1));

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    full_rack = 1'b1;
    end_turn  = 1'b1;
    nxt_ball  = 2'd0;
`ifdef BOWL_TENTH_BONUS_EN
    if (last_frame) begin
      case (ball_out)
        2'd0: begin
          end_turn  = 1'b0;
          nxt_ball  = 2'd1;
          full_rack = all_down;
        end
        2'd1: begin
          if (all_down) begin
            end_turn = 1'b0;
            nxt_ball = 2'd2;
          end
        end
        default: ;
      endcase
    end else
`endif
    if (ball_out == 2'd0 && !all_down) begin
      full_rack = 1'b0;
      end_turn  = 1'b0;
      nxt_ball  = 2'd1;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register sees the values from before this clock edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= IDLE;
      standing_q      <= ALL_PINS;
      rack_mask_q     <= '0;
      pend_end_q      <= 1'b0;
      pend_done_q     <= 1'b0;
      pend_ball_q     <= 2'd0;
      ready_out       <= 1'b0;
      score_valid_out <= 1'b0;
      pins_new_out    <= '0;
      player_out      <= 2'd0;
      ball_out        <= 2'd0;
      frame_out       <= 4'd0;
      rack_req_out    <= 1'b0;
      rack_full_out   <= 1'b0;
      game_over_out   <= 1'b0;
    end else begin
      score_valid_out <= 1'b0;
      if (change) begin
        standing_q <= sampled;
      end

      case (state)
        IDLE, DONE: begin
          if (start_in) begin
            player_out    <= 2'd0;
            ball_out      <= 2'd0;
            frame_out     <= 4'd0;
            standing_q    <= ALL_PINS;
            game_over_out <= 1'b0;
            ready_out     <= 1'b1;
            state         <= READY;
          end
        end

        READY: begin
          if (launch_in) begin
            rack_mask_q <= standing_q;
            ready_out   <= 1'b0;
            state       <= ROLL;
          end
        end

        // timeout is only raised in ROLL and settled only in SETTLE; both
        // imply no change this cycle, so standing_q is already final.
        ROLL, SETTLE: begin
          if (timeout || settled) begin
            score_valid_out <= 1'b1;
            pins_new_out    <= rack_mask_q & ~standing_q;
            state           <= REPORT;
          end else if (change && state == ROLL) begin
            state <= SETTLE;
          end
        end

        REPORT: begin
          rack_req_out  <= 1'b1;
          rack_full_out <= full_rack;
          pend_end_q    <= end_turn;
          pend_done_q   <= end_turn && last_frame && last_player;
          pend_ball_q   <= nxt_ball;
          state         <= RACK;
        end

        RACK: begin
          if (rack_ack_in) begin
            rack_req_out  <= 1'b0;
            rack_full_out <= 1'b0;
            if (rack_full_out) begin
              standing_q <= ALL_PINS;
            end
            if (pend_done_q) begin
              game_over_out <= 1'b1;
              state         <= DONE;
            end else begin
              ready_out <= 1'b1;
              state     <= READY;
              if (pend_end_q) begin
                ball_out <= 2'd0;
                if (last_player) begin
                  player_out <= 2'd0;
                  frame_out  <= frame_out + 4'd1;
                end else begin
                  player_out <= player_out + 2'd1;
                end
              end else begin
                ball_out <= pend_ball_q;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bowl_turn_sequencer.sv
// Directed self-checking bench for bowl_turn_sequencer (default parameters).
module tb_bowl_turn_sequencer;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       start_in;
  logic       launch_in;
  logic       sensor_valid_in;
  logic [9:0] pins_standing_in;
  logic       rack_ack_in;
  logic       ready_out;
  logic       score_valid_out;
  logic [9:0] pins_new_out;
  logic [1:0] player_out;
  logic [1:0] ball_out;
  logic [3:0] frame_out;
  logic       rack_req_out;
  logic       rack_full_out;
  logic       game_over_out;

  int n_cmp = 0;
  int n_mis = 0;

  bowl_turn_sequencer dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .start_in         (start_in),
    .launch_in        (launch_in),
    .sensor_valid_in  (sensor_valid_in),
    .pins_standing_in (pins_standing_in),
    .rack_ack_in      (rack_ack_in),
    .ready_out        (ready_out),
    .score_valid_out  (score_valid_out),
    .pins_new_out     (pins_new_out),
    .player_out       (player_out),
    .ball_out         (ball_out),
    .frame_out        (frame_out),
    .rack_req_out     (rack_req_out),
    .rack_full_out    (rack_full_out),
    .game_over_out    (game_over_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
  endtask

  task automatic launch_ball(input string tag);
    int n;
    n = 0;
    while (!ready_out && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    check({tag, "_ready"}, 32'(ready_out), 32'd1);
    launch_in = 1'b1;
    @(negedge clk_in);
    launch_in = 1'b0;
  endtask

  task automatic wait_score(input string tag, input int budget, output int n);
    n = 0;
    while (!score_valid_out && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    check({tag, "_score"}, 32'(score_valid_out), 32'd1);
  endtask

  task automatic ack_rack(input string tag, input logic exp_full);
    @(negedge clk_in);
    check({tag, "_req"}, 32'(rack_req_out), 32'd1);
    check({tag, "_full"}, 32'(rack_full_out), 32'(exp_full));
    check({tag, "_pulse"}, 32'(score_valid_out), 32'd0);
    rack_ack_in = 1'b1;
    @(negedge clk_in);
    rack_ack_in = 1'b0;
    check({tag, "_req_drop"}, 32'(rack_req_out), 32'd0);
  endtask

  task automatic play_ball(input string tag, input logic [9:0] mask, input logic [9:0] exp_new,
                           input logic exp_full, input int budget, output int n);
    pins_standing_in = 10'h3FF;
    launch_ball(tag);
    pins_standing_in = mask;
    wait_score(tag, budget, n);
    check({tag, "_pins_new"}, 32'(pins_new_out), 32'(exp_new));
    ack_rack(tag, exp_full);
  endtask

  initial begin
    int n;
    int pulses;
    int nb;
    logic [9:0] fl_mask;

    rst_n_in         = 1'b0;
    start_in         = 1'b0;
    launch_in        = 1'b0;
    sensor_valid_in  = 1'b1;
    pins_standing_in = 10'h3FF;
    rack_ack_in      = 1'b0;
    cycles(3);

    // 1. reset state, then a first-ball strike
    check("rst_ready", 32'(ready_out), 32'd0);
    check("rst_score", 32'(score_valid_out), 32'd0);
    check("rst_pins_new", 32'(pins_new_out), 32'd0);
    check("rst_player", 32'(player_out), 32'd0);
    check("rst_ball", 32'(ball_out), 32'd0);
    check("rst_frame", 32'(frame_out), 32'd0);
    check("rst_req", 32'(rack_req_out), 32'd0);
    check("rst_full", 32'(rack_full_out), 32'd0);
    check("rst_over", 32'(game_over_out), 32'd0);
    rst_n_in = 1'b1;
    cycles(2);

    launch_in = 1'b1;
    @(negedge clk_in);
    launch_in = 1'b0;
    cycles(3);
    check("idle_launch_ready", 32'(ready_out), 32'd0);
    check("idle_launch_score", 32'(score_valid_out), 32'd0);

    pulse_start();
    check("start_ready", 32'(ready_out), 32'd1);
    play_ball("t1", 10'h000, 10'h3FF, 1'b1, 100, n);
    check("t1_player", 32'(player_out), 32'd1);
    check("t1_frame", 32'(frame_out), 32'd0);
    check("t1_ball", 32'(ball_out), 32'd0);

    // 2. open frame: sweep after ball 0, full rack and next player after ball 1
    play_ball("t2b0", 10'h0F0, 10'h30F, 1'b0, 100, n);
    check("t2_ball1", 32'(ball_out), 32'd1);
    check("t2_player_same", 32'(player_out), 32'd1);
    play_ball("t2b1", 10'h000, 10'h0F0, 1'b1, 100, n);
    check("t2_player", 32'(player_out), 32'd0);
    check("t2_frame", 32'(frame_out), 32'd1);
    check("t2_ball0", 32'(ball_out), 32'd0);

    // 3. two gutter balls via the roll timeout
    play_ball("t3b0", 10'h3FF, 10'h000, 1'b0, 5000, n);
    check("t3_wait_min", 32'(n >= 4090), 32'd1);
    check("t3_wait_max", 32'(n <= 4100), 32'd1);
    check("t3_ball1", 32'(ball_out), 32'd1);
    play_ball("t3b1", 10'h3FF, 10'h000, 1'b1, 5000, n);
    check("t3_player", 32'(player_out), 32'd1);
    check("t3_frame", 32'(frame_out), 32'd1);

    // 4. flickering mask with pop-ups: one report, only after 16 stable cycles
    pins_standing_in = 10'h3FF;
    launch_ball("t4b0");
    pulses = 0;
    for (int k = 0; k < 9; k++) begin
      fl_mask = 10'h3FF << (k + 1);
      for (int c = 0; c < 10; c++) begin
        pins_standing_in = (c == 5) ? (fl_mask | 10'h001) : fl_mask;
        @(negedge clk_in);
        if (score_valid_out) pulses++;
      end
    end
    check("t4_no_early_report", 32'(pulses), 32'd0);
    wait_score("t4b0", 50, n);
    check("t4_settle_gap", 32'(n), 32'd7);
    check("t4_pins_new", 32'(pins_new_out), 32'h1FF);
    ack_rack("t4b0", 1'b0);
    check("t4_ball1", 32'(ball_out), 32'd1);
    play_ball("t4b1", 10'h000, 10'h200, 1'b1, 100, n);
    check("t4_player", 32'(player_out), 32'd0);
    check("t4_frame", 32'(frame_out), 32'd2);

    // 6. asynchronous reset mid-SETTLE and mid-RACK
    pins_standing_in = 10'h3FF;
    launch_ball("t6a");
    pins_standing_in = 10'h000;
    cycles(5);
    #2 rst_n_in = 1'b0;
    #1;
    check("t6a_ready", 32'(ready_out), 32'd0);
    check("t6a_req", 32'(rack_req_out), 32'd0);
    check("t6a_frame", 32'(frame_out), 32'd0);
    check("t6a_score", 32'(score_valid_out), 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    pins_standing_in = 10'h3FF;
    cycles(1);
    pulse_start();
    launch_ball("t6b");
    pins_standing_in = 10'h000;
    wait_score("t6b", 100, n);
    @(negedge clk_in);
    check("t6b_req_before", 32'(rack_req_out), 32'd1);
    #2 rst_n_in = 1'b0;
    #1;
    check("t6b_req", 32'(rack_req_out), 32'd0);
    check("t6b_full", 32'(rack_full_out), 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    rack_ack_in = 1'b1;
    @(negedge clk_in);
    rack_ack_in = 1'b0;
    cycles(2);
    check("t6_ack_ignored_req", 32'(rack_req_out), 32'd0);
    check("t6_ack_ignored_ready", 32'(ready_out), 32'd0);
    check("t6_ack_ignored_over", 32'(game_over_out), 32'd0);

    // 5. full game of strikes
    pins_standing_in = 10'h3FF;
    pulse_start();
    for (int f = 0; f < 10; f++) begin
      for (int p = 0; p < 2; p++) begin
`ifdef BOWL_TENTH_BONUS_EN
        nb = (f == 9) ? 3 : 1;
`else
        nb = 1;
`endif
        for (int b = 0; b < nb; b++) begin
          check($sformatf("t5_f%0d_p%0d_b%0d_player", f, p, b), 32'(player_out), 32'(p));
          check($sformatf("t5_f%0d_p%0d_b%0d_frame", f, p, b), 32'(frame_out), 32'(f));
          check($sformatf("t5_f%0d_p%0d_b%0d_ball", f, p, b), 32'(ball_out), 32'(b));
          check($sformatf("t5_f%0d_p%0d_b%0d_over", f, p, b), 32'(game_over_out), 32'd0);
          play_ball($sformatf("t5_f%0d_p%0d_b%0d", f, p, b), 10'h000, 10'h3FF, 1'b1, 100, n);
        end
      end
    end
    check("t5_game_over", 32'(game_over_out), 32'd1);
    check("t5_ready_done", 32'(ready_out), 32'd0);
    cycles(3);
    check("t5_over_held", 32'(game_over_out), 32'd1);
    pulse_start();
    check("t5_restart_ready", 32'(ready_out), 32'd1);
    check("t5_restart_over", 32'(game_over_out), 32'd0);
    check("t5_restart_frame", 32'(frame_out), 32'd0);
    check("t5_restart_player", 32'(player_out), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
